clk_div_bank: RTL and testbench

//   NCH-channel programmable clock-enable / divided-clock generator. Successor to the

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_chan.sv | 69 ++++++
 rtl/clk_div_bank.sv | 46 ++++
 tb/tb_clk_div_bank.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock-divider bank.
// Used by the RTL and by the bench reference model.
package clk_div_pkg;

  localparam int DIVW_DEFAULT = 8;

  // Reset divisor of channel i: /2, /4, /8, ...
  // The value saturates at the all-ones divisor.
  function automatic int def_div(input int i, input int divw);
    if (i + 1 >= divw) return (1 << divw) - 1;
    return (2 << i) - 1;
  endfunction

  // Number of high cycles in a period of d+1 cycles, i.e. ceil((d+1)/2).
  function automatic int half(input int d);
    return (d + 2) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active and shadow divisors,
// and the registered clock and tick outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int              DIVW = DIVW_DEFAULT,
  parameter logic [DIVW-1:0] DEF  = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sync,
  input  logic            we,
  input  logic [DIVW-1:0] wdiv,
  output logic            pending,
  output logic            clk_o,
  output logic            tick_o
);

  logic [DIVW-1:0] d, s, cnt, cnt_next, d_eff;
  logic [DIVW:0]   h;
  logic            wrap, apply;

  // A pending shadow is only taken at a period boundary, so a period
  // never changes length once it has started.
  always_comb begin
    wrap     = (cnt == d);
    apply    = pending && (sync || (en && wrap));
    d_eff    = apply ? s : d;
    cnt_next = wrap ? '0 : cnt + 1'b1;
    h        = (DIVW + 1)'(half(int'(d_eff)));
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values; the always_comb block above uses blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      d       <= DEF;
      cnt     <= DEF;
      s       <= '0;
      pending <= 1'b0;
      clk_o   <= 1'b0;
      tick_o  <= 1'b0;
    end else begin
      if (sync) begin
        cnt    <= '0;
        clk_o  <= 1'b1;
        tick_o <= 1'b1;
        if (apply) d <= s;
      end else if (en) begin
        cnt    <= cnt_next;
        tick_o <= (cnt_next == '0);
        clk_o  <= ({1'b0, cnt_next} < h);
        if (apply) d <= s;
      end else begin
        tick_o <= 1'b0;
      end

      // A write on an apply edge re-arms the shadow for the next boundary.
      if (we) begin
        s       <= wdiv;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable divided-clock / tick generators sharing
// enable, phase-realign and a single divisor write port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH  = 3,
  parameter int DIVW = DIVW_DEFAULT,
  parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            sync,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [DIVW-1:0] cfg_div,
  output logic [NCH-1:0]  cfg_pending,
  output logic [NCH-1:0]  clk_o,
  output logic [NCH-1:0]  tick_o
);

  logic [NCH-1:0] we;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [DIVW-1:0] CH_DEF = DIVW'(def_div(i, DIVW));

    // Indices at or beyond NCH match no channel and are dropped.
    assign we[i] = cfg_we && (cfg_ch == CHW'(i));

    clk_div_chan #(
      .DIVW (DIVW),
      .DEF  (CH_DEF)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .sync    (sync),
      .we      (we[i]),
      .wdiv    (cfg_div),
      .pending (cfg_pending[i]),
      .clk_o   (clk_o[i]),
      .tick_o  (tick_o[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios plus random
// traffic, compared every cycle against a period/phase reference model.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  localparam int NCH  = 3;
  localparam int DIVW = DIVW_DEFAULT;
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            sync = 1'b0;
  logic            cfg_we = 1'b0;
  logic [CHW-1:0]  cfg_ch = '0;
  logic [DIVW-1:0] cfg_div = '0;
  logic [NCH-1:0]  cfg_pending, clk_o, tick_o;

  int total = 0;
  int passed = 0;

  // Reference model: period length, phase within the period, shadow.
  int             per[NCH];
  int             ph[NCH];
  int             sh[NCH];
  bit             pend[NCH];
  logic [NCH-1:0] exp_clk, exp_tick, exp_pend;

  clk_div_bank #(.NCH(NCH), .DIVW(DIVW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sync        (sync),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_pending (cfg_pending),
    .clk_o       (clk_o),
    .tick_o      (tick_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model(input bit r, input bit e, input bit s, input bit w,
                       input int ch, input int dv);
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        per[i] = def_div(i, DIVW) + 1;
        ph[i]  = per[i] - 1;
        sh[i]  = 0;
        pend[i] = 1'b0;
        exp_clk[i]  = 1'b0;
        exp_tick[i] = 1'b0;
      end else begin
        if (s) begin
          if (pend[i]) begin per[i] = sh[i] + 1; pend[i] = 1'b0; end
          ph[i] = 0;
          exp_clk[i]  = 1'b1;
          exp_tick[i] = 1'b1;
        end else if (e) begin
          ph[i]++;
          if (ph[i] == per[i]) begin
            ph[i] = 0;
            if (pend[i]) begin per[i] = sh[i] + 1; pend[i] = 1'b0; end
          end
          exp_tick[i] = (ph[i] == 0);
          exp_clk[i]  = (ph[i] < (per[i] + 1) / 2);
        end else begin
          exp_tick[i] = 1'b0;
        end
        if (w && ch == i) begin sh[i] = dv; pend[i] = 1'b1; end
      end
      exp_pend[i] = pend[i];
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s, input bit w,
                      input int ch, input int dv);
    rst = r; en = e; sync = s; cfg_we = w;
    cfg_ch = CHW'(ch); cfg_div = DIVW'(dv);
    @(posedge clk);
    model(r, e, s, w, ch, dv);
    #1;
    check("clk_o", 16'(clk_o), 16'(exp_clk));
    check("tick_o", 16'(tick_o), 16'(exp_tick));
    check("cfg_pending", 16'(cfg_pending), 16'(exp_pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 0, 0, 0, 0);
  endtask

  // Advance with en=1 until ch0 sits on the last cycle of its period.
  task automatic hunt_wrap0();
    bit found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (ph[0] == per[0] - 1) found = 1'b1;
      else step(0, 1, 0, 0, 0, 0);
    end
    total++;
    assert (found) passed++;
    else $error("FAIL wrap_hunt: got no ch0 wrap expected wrap within 300 cycles");
  endtask

  initial begin
    // 1: reset state, then default periods 2/4/8 with coincident first tick
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_clk", 16'(clk_o), 16'd0);
    check("reset_tick", 16'(tick_o), 16'd0);
    step(0, 1, 0, 0, 0, 0);
    check("first_tick", 16'(tick_o), 16'b111);
    run(15);

    // 2: ch0 div=4 written mid-period
    run(3);
    step(0, 1, 0, 1, 0, 4);
    check("pend_after_write", 16'(cfg_pending[0]), 16'd1);
    run(20);

    // 3: ch1 div=0, then div=255
    step(0, 1, 0, 1, 1, 0);
    run(10);
    step(0, 1, 0, 1, 1, 255);
    run(520);

    // 4: freeze for 5 cycles with a write to ch2 during the freeze
    run(2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 5);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("frozen_tick", 16'(tick_o), 16'd0);
    run(20);

    // 5: write ch2 div=2 then sync; then sync and rst together
    step(0, 1, 0, 1, 2, 2);
    step(0, 1, 1, 0, 0, 0);
    check("sync_tick", 16'(tick_o), 16'b111);
    check("sync_pend", 16'(cfg_pending), 16'd0);
    run(9);
    step(1, 1, 1, 1, 0, 7);
    check("sync_rst_clk", 16'(clk_o), 16'd0);
    check("sync_rst_pend", 16'(cfg_pending), 16'd0);
    run(10);

    // 6: write coincident with ch0 wrap (old pending 6, new 9)
    step(0, 1, 0, 1, 0, 4);
    hunt_wrap0();
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 6);
    hunt_wrap0();
    step(0, 1, 0, 1, 0, 9);
    check("coincident_pend", 16'(cfg_pending[0]), 16'd1);
    check("coincident_tick", 16'(tick_o[0]), 16'd1);
    run(25);
    step(0, 1, 0, 1, 3, 1);
    run(12);

    // Random traffic, including out-of-range channel writes
    for (int k = 0; k < 400; k++) begin
      int dv;
      dv = ($urandom % 10 == 0) ? int'($urandom % 256) : int'($urandom % 8);
      step($urandom % 97 == 0, $urandom % 5 != 0, $urandom % 41 == 0,
           $urandom % 6 == 0, int'($urandom % 4), dv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
